// File: rtl/ram_frame_reader.sv
// ram_frame_reader
//   Drains one full ping-pong buffer (DEPTH samples) from a RAM read port
//   into a valid/ready stream. It marks the final sample with m_last_o and
//   counts completed frames.
//
//   Optional feature (macro RAM_FRAME_READER_HEADER_EN):
//     Each frame is preceded by one header word. That word is the current
//     frame_count_o, zero-extended to WIDTH bits.
//
//   Ports
//     clk_i, rst_ni     clock, asynchronous active-low reset
//     buf_ready_i       pulse: a full buffer is ready to be read
//     rd_data_i/valid_i read-port sample and its valid flag
//     rd_ready_o        this block takes rd_data_i this cycle
//     m_data_o/valid_o/last_o/ready_i  downstream stream
//     busy_o            high whenever the FSM is not in IDLE
//     overrun_o         pulse: buf_ready_i arrived while busy
//     frame_count_o     completed frames (16-bit, wraps)
//     sample_count_o    samples accepted in the current frame
module ram_frame_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  buf_ready_i,
  input  logic [WIDTH-1:0]      rd_data_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  output logic [WIDTH-1:0]      m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [15:0]           frame_count_o,
  output logic [ADDR_WIDTH:0]   sample_count_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef RAM_FRAME_READER_HEADER_EN
  typedef enum logic [1:0] {IDLE, HEADER, DRAIN, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     sample_cnt;
  logic [15:0]       frame_cnt;
  logic              overrun_q;

  // Two-entry output FIFO. Entry 0 is always the head.
  logic [WIDTH-1:0]  d0, d1;
  logic              l0, l1;
  logic [1:0]        cnt;

  logic              push, push_last, pop, accept, frame_done;
  logic [WIDTH-1:0]  push_data;

  assign m_valid_o      = (cnt != 2'd0);
  assign m_data_o       = d0;
  // A stale last flag must not be visible once the head entry has been popped.
  assign m_last_o       = l0 & m_valid_o;
  assign busy_o         = (state_q != IDLE);
  assign overrun_o      = overrun_q;
  assign frame_count_o  = frame_cnt;
  assign sample_count_o = sample_cnt;

  // Uses only registered terms, so there is no combinational path from the inputs.
  assign rd_ready_o = (state_q == DRAIN) && (cnt != 2'd2) && (sample_cnt < FULL_CNT);
  assign accept     = rd_valid_i && rd_ready_o;
  assign pop        = m_valid_o && m_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_data  = rd_data_i;
    push_last  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_ready_i) begin
`ifdef RAM_FRAME_READER_HEADER_EN
          state_d = HEADER;
`else
          state_d = DRAIN;
`endif
        end
      end
`ifdef RAM_FRAME_READER_HEADER_EN
      HEADER: begin
        if (cnt != 2'd2) begin
          push      = 1'b1;
          push_data = WIDTH'(frame_cnt);
          state_d   = DRAIN;
        end
      end
`endif
      DRAIN: begin
        if (accept) begin
          push      = 1'b1;
          push_last = (sample_cnt == LAST_IDX);
          if (sample_cnt == LAST_IDX) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Leave FLUSH on the same edge that pops the final entry.
        if (cnt == 2'd0 || (cnt == 2'd1 && pop)) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_cnt <= '0;
      frame_cnt  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && buf_ready_i) sample_cnt <= '0;
      else if (accept)                    sample_cnt <= sample_cnt + CW'(1);
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      overrun_q <= buf_ready_i && (state_q != IDLE);
    end
  end

  // Writes go to the first free slot. A pop shifts entry 1 into the head.
  // When a push and a pop happen together the count stays the same and order is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= push_data; l0 <= push_last;
          end else begin
            d1 <= push_data; l1 <= push_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= push_data; l0 <= push_last;
          end else begin
            d0 <= d1;        l0 <= l1;
            d1 <= push_data; l1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_frame_reader.sv
module tb_ram_frame_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             buf_ready_i;
  logic [WIDTH-1:0] rd_data_i;
  logic             rd_valid_i;
  logic             rd_ready_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_last_o;
  logic             m_ready_i;
  logic             busy_o;
  logic             overrun_o;
  logic [15:0]      frame_count_o;
  logic [2:0]       sample_count_o;

  ram_frame_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .buf_ready_i(buf_ready_i),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i), .busy_o(busy_o), .overrun_o(overrun_o),
    .frame_count_o(frame_count_o), .sample_count_o(sample_count_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int gcyc  = 0;
  int ovr_cnt = 0;
  logic [WIDTH:0] cap_q[$];   // {last, data} of each output handshake
  int             cap_t[$];   // cycle stamp of each handshake
  bit stall_stable, saw_block;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Record output handshakes and overrun pulses between clock edges.
  always @(negedge clk) begin
    if (m_valid_o && m_ready_i) begin
      cap_q.push_back({m_last_o, m_data_o});
      cap_t.push_back(gcyc);
    end
    if (overrun_o) ovr_cnt++;
  end

  task automatic do_reset();
    rst_ni = 1'b0; buf_ready_i = 1'b0; rd_valid_i = 1'b0;
    rd_data_i = '0; m_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    cap_q.delete(); cap_t.delete(); ovr_cnt = 0;
  endtask

  // Drives one frame: base, base+1, ... The stream is stalled for stall_len
  // cycles from stall_at. buf_ready_i is pulsed again at cycle ovr_at.
  // This task only drives stimulus and records stall observations.
  task automatic run_frame(input logic [31:0] base, input int stall_at, input int stall_len,
                           input int ovr_at, output int start, output bit to);
    int  idx = 0;
    int  cyc = 0;
    bit  acc, stall, have;
    logic [WIDTH-1:0] held;
    have = 0; stall_stable = 1; saw_block = 0;
    @(posedge clk); #1;
    buf_ready_i = 1'b1; rd_valid_i = 1'b1; rd_data_i = base; m_ready_i = 1'b1;
    @(posedge clk); #1;
    buf_ready_i = 1'b0;
    start = gcyc;
    while (cyc < 200) begin
      stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      m_ready_i   = !stall;
      buf_ready_i = (cyc == ovr_at);
      @(negedge clk);
      acc = rd_valid_i && rd_ready_o;
      if (stall && m_valid_o) begin
        if (!have) begin held = m_data_o; have = 1; end
        else if (m_data_o !== held) stall_stable = 0;
        if (!rd_ready_o) saw_block = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < DEPTH) rd_data_i = base + idx;
        else rd_valid_i = 1'b0;
      end
      if (idx == DEPTH && !busy_o) break;
    end
    to = (cyc >= 200);
    m_ready_i = 1'b1; buf_ready_i = 1'b0; rd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; buf_ready_i = 1'b0; rd_valid_i = 1'b0;
    rd_data_i = '0; m_ready_i = 1'b1;
    #1;
    tests++;
    if ({m_valid_o, m_last_o, rd_ready_o, busy_o, overrun_o} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b want 00000",
                        {m_valid_o, m_last_o, rd_ready_o, busy_o, overrun_o});
    end
    tests++;
    if ({m_data_o, frame_count_o, sample_count_o} !== '0) begin
      fails++; $display("FAIL reset_values data=%h fc=%0d sc=%0d want 0",
                        m_data_o, frame_count_o, sample_count_o);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int st; bit to;
    do_reset();
    run_frame(32'h10, -1, 0, -1, st, to);
    tests++;
    if (to || cap_q.size() != 4) begin
      fails++; $display("FAIL basic_count got %0d words timeout=%0d want 4", cap_q.size(), to);
    end
    for (int i = 0; i < cap_q.size() && i < 4; i++) begin
      tests++;
      if (cap_q[i] !== {(i == 3), 32'h10 + 32'(i)} || cap_t[i] != st + 1 + i) begin
        fails++; $display("FAIL basic_word%0d got %h@%0d want %h@%0d", i, cap_q[i], cap_t[i],
                          {(i == 3), 32'h10 + 32'(i)}, st + 1 + i);
      end
    end
    tests++;
    if (frame_count_o !== 16'd1 || sample_count_o !== 3'd4 || rd_ready_o !== 1'b0) begin
      fails++; $display("FAIL basic_end fc=%0d sc=%0d rdy=%b want 1 4 0",
                        frame_count_o, sample_count_o, rd_ready_o);
    end
  endtask

  task automatic test_stall();
    int st; bit to;
    do_reset();
    run_frame(32'h20, 1, 5, -1, st, to);
    tests++;
    if (!saw_block || !stall_stable) begin
      fails++; $display("FAIL stall_hold block=%0d stable=%0d want 1 1", saw_block, stall_stable);
    end
    tests++;
    if (to || cap_q.size() != 4) begin
      fails++; $display("FAIL stall_count got %0d words want 4", cap_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < 4; i++) begin
      tests++;
      if (cap_q[i] !== {(i == 3), 32'h20 + 32'(i)}) begin
        fails++; $display("FAIL stall_word%0d got %h want %h", i, cap_q[i], {(i == 3), 32'h20 + 32'(i)});
      end
    end
  endtask

  task automatic test_overrun();
    int st; bit to;
    do_reset();
    run_frame(32'h60, -1, 0, 1, st, to);
    tests++;
    if (ovr_cnt != 1) begin
      fails++; $display("FAIL overrun_pulses got %0d want 1", ovr_cnt);
    end
    tests++;
    if (to || cap_q.size() != 4 || frame_count_o !== 16'd1) begin
      fails++; $display("FAIL overrun_frame words=%0d fc=%0d want 4 1", cap_q.size(), frame_count_o);
    end
  endtask

  task automatic test_reset_midframe();
    int st; bit to;
    do_reset();
    @(posedge clk); #1;
    buf_ready_i = 1'b1; rd_valid_i = 1'b1; rd_data_i = 32'h30; m_ready_i = 1'b0;
    @(posedge clk); #1 buf_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (sample_count_o !== 3'd2 || m_valid_o !== 1'b1) begin
      fails++; $display("FAIL mid_pre sc=%0d vld=%b want 2 1", sample_count_o, m_valid_o);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({m_valid_o, m_last_o, rd_ready_o, busy_o, overrun_o, m_data_o, frame_count_o, sample_count_o} !== '0) begin
      fails++; $display("FAIL mid_reset vld=%b last=%b rdy=%b busy=%b data=%h sc=%0d want all 0",
                        m_valid_o, m_last_o, rd_ready_o, busy_o, m_data_o, sample_count_o);
    end
    rd_valid_i = 1'b0; m_ready_i = 1'b1;
    @(posedge clk); #1 rst_ni = 1'b1;
    cap_q.delete(); cap_t.delete();
    run_frame(32'h40, -1, 0, -1, st, to);
    tests++;
    if (to || cap_q.size() != 4 || frame_count_o !== 16'd1) begin
      fails++; $display("FAIL mid_after words=%0d fc=%0d want 4 1", cap_q.size(), frame_count_o);
    end
    for (int i = 0; i < cap_q.size() && i < 4; i++) begin
      tests++;
      if (cap_q[i] !== {(i == 3), 32'h40 + 32'(i)}) begin
        fails++; $display("FAIL mid_word%0d got %h want %h", i, cap_q[i], {(i == 3), 32'h40 + 32'(i)});
      end
    end
  endtask

  task automatic test_back_to_back();
    int st; bit to1, to2;
    do_reset();
    run_frame(32'h70, -1, 0, -1, st, to1);
    run_frame(32'h80, -1, 0, -1, st, to2);
    tests++;
    if (to1 || to2 || ovr_cnt != 0 || frame_count_o !== 16'd2) begin
      fails++; $display("FAIL b2b ovr=%0d fc=%0d want 0 2", ovr_cnt, frame_count_o);
    end
    tests++;
    if (cap_q.size() != 8 || cap_q[3] !== {1'b1, 32'h73} || cap_q[4] !== {1'b0, 32'h80}
        || cap_q[7] !== {1'b1, 32'h83}) begin
      fails++; $display("FAIL b2b_words got %0d words want 8 with last at 3 and 7", cap_q.size());
    end
  endtask

  task automatic test_header();
    int st; bit to;
    logic [WIDTH:0] exp;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      cap_q.delete(); cap_t.delete();
      run_frame(32'h50 + 32'(f * 16), -1, 0, -1, st, to);
      tests++;
      if (to || cap_q.size() != 5) begin
        fails++; $display("FAIL hdr%0d_count got %0d words want 5", f, cap_q.size());
      end
      for (int i = 0; i < cap_q.size() && i < 5; i++) begin
        exp = (i == 0) ? {1'b0, 32'(f)} : {(i == 4), 32'h50 + 32'(f * 16) + 32'(i - 1)};
        tests++;
        if (cap_q[i] !== exp) begin
          fails++; $display("FAIL hdr%0d_word%0d got %h want %h", f, i, cap_q[i], exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef RAM_FRAME_READER_HEADER_EN
    test_header();
`else
    test_basic();
    test_stall();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
